// File: rtl/alpha_recursion_pipe_if.sv
// Handshake bundle between the branch-metric stage, the alpha recursion unit
// and the LLR stage.
//   in_valid/in_ready : per-step branch-metric transfer
//   in_sop/in_eop     : code-block framing, qualified by in_valid
//   in_g1/in_g2       : signed branch metrics (GW bits)
//   out_valid/out_ready : alpha-vector transfer
//   out_alpha         : 8 packed signed state metrics, state s at [s*MW +: MW]
//   out_k             : trellis step index of out_alpha
//   out_last          : out_alpha belongs to the block's last step
//   err_sop           : one-cycle protocol-error pulse
// master = producer of metrics / consumer of alphas, slave = recursion unit.
interface alpha_recursion_pipe_if #(
  parameter int MW = 16,
  parameter int GW = 16,
  parameter int KW = 13
);
  logic          in_valid;
  logic          in_ready;
  logic          in_sop;
  logic          in_eop;
  logic [GW-1:0] in_g1;
  logic [GW-1:0] in_g2;
  logic            out_valid;
  logic            out_ready;
  logic [8*MW-1:0] out_alpha;
  logic [KW-1:0]   out_k;
  logic            out_last;
  logic            err_sop;

  modport master (
    output in_valid, in_sop, in_eop, in_g1, in_g2, out_ready,
    input  in_ready, out_valid, out_alpha, out_k, out_last, err_sop
  );

  modport slave (
    input  in_valid, in_sop, in_eop, in_g1, in_g2, out_ready,
    output in_ready, out_valid, out_alpha, out_k, out_last, err_sop
  );
endinterface

// File: rtl/alpha_recursion_pipe.sv
// Forward state-metric (alpha) recursion for the 8-state LTE turbo SISO
// decoder, max-log-MAP. Each accepted step emits the alpha vector entering
// that step (one cycle later) and updates the internal metrics with the
// normalised, saturated recursion result.
// Ports:
//   clk  : clock
//   rst  : synchronous reset, active low
//   bus  : alpha_recursion_pipe_if.slave (handshake, framing, metrics, alphas)
// Parameters: MW metric width, GW branch-metric width (GW <= MW),
//   INIT_NEG initial penalty for states 1..7, KW step-counter width.
// Optional build macro LOGMAP_CORR_EN: replaces max() by max*() with an
//   8-entry log-MAP correction LUT. Undefined = pure max-log.
module alpha_recursion_pipe #(
  parameter int MW       = 16,
  parameter int GW       = 16,
  parameter int INIT_NEG = 128,
  parameter int KW       = 13
) (
  input logic clk,
  input logic rst,
  alpha_recursion_pipe_if.slave bus
);

  // Recursion sums need two guard bits over the metric width.
  localparam int XW = MW + 2;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic signed [MW-1:0] INIT_V  = MW'(-INIT_NEG);
  localparam logic signed [XW:0]   SAT_MAX = {4'b0000, {(MW-1){1'b1}}};
  localparam logic signed [XW:0]   SAT_MIN = {4'b1111, {(MW-1){1'b0}}};

  // Clamp a wide difference into the MW-bit signed metric range.
  function automatic logic signed [MW-1:0] sat_mw(input logic signed [XW:0] x);
    if (x > SAT_MAX) begin
      sat_mw = SAT_MAX[MW-1:0];
    end else if (x < SAT_MIN) begin
      sat_mw = SAT_MIN[MW-1:0];
    end else begin
      sat_mw = x[MW-1:0];
    end
  endfunction

`ifdef LOGMAP_CORR_EN
  // Jacobian correction term, indexed by min(|a-b|>>1, 7).
  function automatic logic [2:0] corr_lut(input logic [2:0] idx);
    case (idx)
      3'd0:    corr_lut = 3'd5;
      3'd1:    corr_lut = 3'd4;
      3'd2:    corr_lut = 3'd3;
      3'd3:    corr_lut = 3'd2;
      3'd4:    corr_lut = 3'd2;
      3'd5:    corr_lut = 3'd1;
      3'd6:    corr_lut = 3'd1;
      default: corr_lut = 3'd0;
    endcase
  endfunction

  // max*(a,b): strict-greater select (tie -> b) plus saturated correction.
  function automatic logic signed [XW-1:0] fmax(input logic signed [XW-1:0] a,
                                                input logic signed [XW-1:0] b);
    logic signed [XW-1:0] m;
    logic [XW:0] d;
    logic [XW:0] ad;
    logic [2:0]  idx;
    logic [XW:0] sum;
    if (a > b) begin
      m = a;
    end else begin
      m = b;
    end
    d = {a[XW-1], a} - {b[XW-1], b};
    if (d[XW]) begin
      ad = ~d + {{XW{1'b0}}, 1'b1};
    end else begin
      ad = d;
    end
    // Any bit at or above 16 means |a-b|>>1 exceeds 7.
    if (ad[XW:4] != {(XW-3){1'b0}}) begin
      idx = 3'd7;
    end else begin
      idx = ad[3:1];
    end
    sum = {m[XW-1], m} + {{(XW-2){1'b0}}, corr_lut(idx)};
    // The correction is non-negative, so only positive overflow can occur.
    if (!sum[XW] && sum[XW-1]) begin
      fmax = {1'b0, {(XW-1){1'b1}}};
    end else begin
      fmax = sum[XW-1:0];
    end
  endfunction
`else
  // Plain max: strict greater-than, tie selects b.
  function automatic logic signed [XW-1:0] fmax(input logic signed [XW-1:0] a,
                                                input logic signed [XW-1:0] b);
    if (a > b) begin
      fmax = a;
    end else begin
      fmax = b;
    end
  endfunction
`endif

  logic signed [MW-1:0] a_r [8];
  logic [KW-1:0]        k_cnt_r;
  state_t               state_r;
  logic                 out_valid_r;
  logic [8*MW-1:0]      out_alpha_r;
  logic [KW-1:0]        out_k_r;
  logic                 out_last_r;
  logic                 err_sop_r;

  logic                 in_ready_s;
  logic                 accept_s;
  logic                 proto_err_s;
  logic [KW-1:0]        k_next_s;
  logic signed [MW-1:0] v_s [8];
  logic signed [XW-1:0] ve_s [8];
  logic signed [XW-1:0] g1_s;
  logic signed [XW-1:0] g2_s;
  logic signed [XW-1:0] n_s [8];
  logic signed [MW-1:0] a_next_s [8];
  logic [8*MW-1:0]      v_packed_s;

  // Handshake, framing decode and the full recursion datapath for one step.
  always_comb begin
    in_ready_s = bus.out_ready || !out_valid_r;
    accept_s   = bus.in_valid && in_ready_s;
    if (bus.in_sop) begin
      k_next_s = {KW{1'b0}};
    end else begin
      k_next_s = k_cnt_r;
    end
    // Missing sop while idle, or a fresh sop mid-block, is a framing error.
    if (state_r == IDLE) begin
      proto_err_s = !bus.in_sop;
    end else begin
      proto_err_s = bus.in_sop;
    end

    g1_s = {{(XW-GW){bus.in_g1[GW-1]}}, bus.in_g1};
    g2_s = {{(XW-GW){bus.in_g2[GW-1]}}, bus.in_g2};

    v_packed_s = {(8*MW){1'b0}};
    for (int s = 0; s < 8; s++) begin
      if (bus.in_sop) begin
        v_s[s] = (s == 0) ? {MW{1'b0}} : INIT_V;
      end else begin
        v_s[s] = a_r[s];
      end
      ve_s[s] = {{2{v_s[s][MW-1]}}, v_s[s]};
      v_packed_s[s*MW +: MW] = v_s[s];
    end

    n_s[0] = fmax(ve_s[0] + g1_s, ve_s[1] - g1_s);
    n_s[1] = fmax(ve_s[2] - g2_s, ve_s[3] + g2_s);
    n_s[2] = fmax(ve_s[4] + g2_s, ve_s[5] - g2_s);
    n_s[3] = fmax(ve_s[6] - g1_s, ve_s[7] + g1_s);
    n_s[4] = fmax(ve_s[0] - g1_s, ve_s[1] + g1_s);
    n_s[5] = fmax(ve_s[2] + g2_s, ve_s[3] - g2_s);
    n_s[6] = fmax(ve_s[4] - g2_s, ve_s[5] + g2_s);
    n_s[7] = fmax(ve_s[6] + g1_s, ve_s[7] - g1_s);

    // Normalise against state 0 so state 0 is always zero after an update.
    for (int s = 0; s < 8; s++) begin
      a_next_s[s] = sat_mw({n_s[s][XW-1], n_s[s]} - {n_s[0][XW-1], n_s[0]});
    end
  end

  // State metrics, step counter, block FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < 8; s++) begin
        a_r[s] <= (s == 0) ? {MW{1'b0}} : INIT_V;
      end
      k_cnt_r     <= {KW{1'b0}};
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      out_alpha_r <= {(8*MW){1'b0}};
      out_k_r     <= {KW{1'b0}};
      out_last_r  <= 1'b0;
      err_sop_r   <= 1'b0;
    end else begin
      err_sop_r <= accept_s && proto_err_s;
      if (accept_s) begin
        for (int s = 0; s < 8; s++) begin
          a_r[s] <= a_next_s[s];
        end
        k_cnt_r     <= k_next_s + {{(KW-1){1'b0}}, 1'b1};
        out_valid_r <= 1'b1;
        out_alpha_r <= v_packed_s;
        out_k_r     <= k_next_s;
        out_last_r  <= bus.in_eop;
        case (state_r)
          IDLE: begin
            // sop+eop together is a one-step block and never enters RUN.
            if (bus.in_sop && !bus.in_eop) begin
              state_r <= RUN;
            end else begin
              state_r <= IDLE;
            end
          end
          RUN: begin
            if (bus.in_eop) begin
              state_r <= IDLE;
            end else begin
              state_r <= RUN;
            end
          end
          default: state_r <= IDLE;
        endcase
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_alpha = out_alpha_r;
  assign bus.out_k     = out_k_r;
  assign bus.out_last  = out_last_r;
  assign bus.err_sop   = err_sop_r;

endmodule
